// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; special cases (divide by zero, MIN/-1) bypass the iteration.
module div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            funct3lo,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] res
);
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e         state_q, state_d;
    logic           rem_sel_q, rem_sel_d;
    logic           neg_quo_q, neg_quo_d;
    logic           neg_rem_q, neg_rem_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]   res_q, res_d;
    logic           done_q, done_d;

    logic           is_signed, a_neg, b_neg, div_zero, overflow;
    logic [W-1:0]   abs_a, abs_b;
    logic [W+1:0]   shifted, trial;
    logic           ge;

    assign is_signed = ~funct3lo[0];
    assign a_neg     = is_signed & a[W-1];
    assign b_neg     = is_signed & b[W-1];
    assign abs_a     = a_neg ? -a : a;
    assign abs_b     = b_neg ? -b : b;
    assign div_zero  = (b == '0);
    assign overflow  = is_signed & (a == MinVal) & (b == '1);

    // Extra top bit keeps the trial subtraction sign-correct for any unsigned divisor.
    assign shifted = {rem_q, quo_q[W-1]};
    assign trial   = shifted - {2'b00, dvs_q};
    assign ge      = ~trial[W+1];

    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    rem_sel_d = funct3lo[1];
                    dvs_d     = abs_b;
                    cnt_d     = CNT_W'(W);
                    if (div_zero) begin
                        // Raw dividend, no sign fixup: REM returns a, DIV returns all ones.
                        quo_d     = '1;
                        rem_d     = {1'b0, a};
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = StFin;
                    end else if (overflow) begin
                        quo_d     = MinVal;
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = StFin;
                    end else begin
                        quo_d     = abs_a;
                        rem_d     = '0;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = ge ? trial[W:0] : shifted[W:0];
                quo_d = {quo_q[W-2:0], ge};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                if (rem_sel_q) begin
                    res_d = neg_rem_q ? -rem_q[W-1:0] : rem_q[W-1:0];
                end else begin
                    res_d = neg_quo_q ? -quo_q : quo_q;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
            res_d   = res_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign res  = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, handshake corner sequences,
// and a randomized sweep against an arithmetic reference model.
module tb_div_unit;
    localparam int W = 32;
    localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

    logic         clk, rst_n, start, flush, busy, done;
    logic [1:0]   funct3lo;
    logic [W-1:0] a, b, res;

    int n_pass   = 0;
    int n_checks = 0;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .funct3lo (funct3lo),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .res      (res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    // Reference: RISC-V M-extension semantics with plain 64-bit arithmetic.
    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint sx, sy, r;
        if (y == 0) return op[1] ? x : '1;
        if (op[0]) return op[1] ? (x % y) : (x / y);
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = op[1] ? (sx % sy) : (sx / sy);
        return r[W-1:0];
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [W-1:0] x,
                                     input logic [W-1:0] y);
        if (y == 0) return 1;
        if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic add_vec(input string n, input logic [1:0] op, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] e, input int l);
        vec_t v;
        v.name = n; v.op = op; v.x = x; v.y = y; v.exp = e; v.lat = l;
        vecs.push_back(v);
    endtask

    // Present one request for a single edge, then scramble the operand inputs.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        funct3lo = op; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0; funct3lo = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input int offset, output int lat, output bit busy_ok);
        bit seen;
        lat = -1; busy_ok = 1'b1; seen = 1'b0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            step();
            if (done) begin
                seen = 1'b1;
                lat  = offset + k;
                if (busy) busy_ok = 1'b0;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input string n, input logic [1:0] op, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] e, input int l);
        int lat;
        bit bok;
        issue(op, x, y);
        wait_done(0, lat, bok);
        check({n, ".res"}, res, e);
        check({n, ".lat"}, 32'(lat), 32'(l));
        check({n, ".busy"}, {31'b0, bok}, 32'd1);
        step();
        check({n, ".pulse"}, {31'b0, done}, 32'd0);
    endtask

    task automatic count_no_done(input string n, input int cycles);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (done) seen++;
        end
        check(n, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat;
        bit bok;
        logic [1:0]   op;
        logic [W-1:0] x, y;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3lo = 2'b00; a = '0; b = '0;
        step();
        step();
        check("reset.busy", {31'b0, busy}, 32'd0);
        check("reset.done", {31'b0, done}, 32'd0);
        check("reset.res", res, 32'd0);
        rst_n = 1'b1;
        count_no_done("reset.no_done", 5);

        add_vec("divu_7_2",    OpDivu, 32'd7,           32'd2,           32'd3,           33);
        add_vec("remu_7_2",    OpRemu, 32'd7,           32'd2,           32'd1,           33);
        add_vec("div_m7_2",    OpDiv,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   33);
        add_vec("rem_m7_2",    OpRem,  32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   33);
        add_vec("rem_7_m2",    OpRem,  32'd7,           32'hFFFF_FFFE,   32'd1,           33);
        add_vec("divu_max_16", OpDivu, 32'hFFFF_FFFF,   32'h10,          32'h0FFF_FFFF,   33);
        add_vec("div_min_2",   OpDiv,  32'h8000_0000,   32'd2,           32'hC000_0000,   33);
        add_vec("div_by0",     OpDiv,  32'd5,           32'd0,           32'hFFFF_FFFF,   1);
        add_vec("remu_by0",    OpRemu, 32'd5,           32'd0,           32'd5,           1);
        add_vec("rem_neg_by0", OpRem,  32'hFFFF_FFF9,   32'd0,           32'hFFFF_FFF9,   1);
        add_vec("divu_by0",    OpDivu, 32'h1234_5678,   32'd0,           32'hFFFF_FFFF,   1);
        add_vec("div_ovf",     OpDiv,  32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1);
        add_vec("rem_ovf",     OpRem,  32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1);
        add_vec("divu_min_m1", OpDivu, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           33);

        foreach (vecs[i]) run_vec(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y,
                                  vecs[i].exp, vecs[i].lat);

        // Back-to-back: new start in the done cycle is accepted, res shows the finished result.
        issue(OpDivu, 32'd100, 32'd7);
        wait_done(0, lat, bok);
        check("b2b.first_res", res, 32'd14);
        issue(OpRemu, 32'd100, 32'd7);
        check("b2b.accepted", {31'b0, busy}, 32'd1);
        check("b2b.no_done", {31'b0, done}, 32'd0);
        wait_done(0, lat, bok);
        check("b2b.second_res", res, 32'd2);
        check("b2b.second_lat", 32'(lat), 32'd33);
        step();

        // Start pulses while busy are ignored.
        issue(OpDivu, 32'd1000, 32'd10);
        repeat (5) step();
        start = 1'b1; funct3lo = OpDivu; a = 32'd9; b = 32'd3;
        step();
        step();
        start = 1'b0;
        wait_done(7, lat, bok);
        check("busy_start.res", res, 32'd100);
        check("busy_start.lat", 32'(lat), 32'd33);
        check("busy_start.busy", {31'b0, bok}, 32'd1);
        step();

        // Flush mid-calculation: abort with no done and res untouched.
        issue(OpDivu, 32'd50, 32'd5);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.busy", {31'b0, busy}, 32'd0);
        check("flush.done", {31'b0, done}, 32'd0);
        check("flush.res", res, 32'd100);
        count_no_done("flush.no_done", 40);
        run_vec("after_flush", OpDiv, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);

        // Flush wins over start in idle.
        start = 1'b1; flush = 1'b1; funct3lo = OpDivu; a = 32'd8; b = 32'd2;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush_start.busy", {31'b0, busy}, 32'd0);
        count_no_done("flush_start.no_done", 40);
        check("flush_start.res", res, 32'hFFFF_FFF2);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            x  = pick();
            y  = pick();
            run_vec($sformatf("rand%0d_op%0d_%08h_%08h", i, op, x, y), op, x, y,
                    model(op, x, y), model_lat(op, x, y));
        end

        // Asynchronous reset between edges mid-calculation.
        run_vec("pre_reset", OpRemu, 32'd1000, 32'd7, 32'd6, 33);
        issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        check("arst.busy", {31'b0, busy}, 32'd0);
        check("arst.done", {31'b0, done}, 32'd0);
        check("arst.res", res, 32'd0);
        #2 rst_n = 1'b1;
        count_no_done("arst.no_done", 40);
        run_vec("after_arst", OpDivu, 32'd7, 32'd2, 32'd3, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
